// File: rtl/pause_sequencer.sv
// Frame-aligned pause controller: merges requester, user-toggle and OSD pause
// sources and halts the core CPU only on vblank rising edges (or after a timeout).
module pause_sequencer #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DIM_CYCLES = 120000000,
  parameter int unsigned VB_TIMEOUT = 1000000
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            cpu_reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  input  logic            user_button,
  input  logic            osd_status,
  input  logic [1:0]      options,
  input  logic            vblank,
  output logic            pause_cpu,
  output logic            dim_video
);

  localparam int unsigned TW = (VB_TIMEOUT > 1) ? $clog2(VB_TIMEOUT + 1) : 1;
  localparam int unsigned DW = (DIM_CYCLES > 1) ? $clog2(DIM_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(VB_TIMEOUT - 1);
  localparam logic [DW-1:0] DIM_MAX = DW'(DIM_CYCLES);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_ARM    = 2'd1,
    S_PAUSED = 2'd2,
    S_RESUME = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_vblank_q;
  logic            r_btn_q;
  logic            r_primed;
  logic            r_toggle;
  logic [TW-1:0]   r_to_cnt;
  logic [TW-1:0]   w_to_cnt_next;
  logic [DW-1:0]   r_dim_cnt;
  logic            w_vb_rise;
  logic            w_btn_rise;
  logic            w_want;
  logic            w_to_done;
  logic            w_halted;

  // r_primed masks edges until one real sample exists, so inputs held high
  // through reset do not look like rising edges on the first cycle.
  assign w_vb_rise  = vblank & ~r_vblank_q & r_primed;
  assign w_btn_rise = user_button & ~r_btn_q & r_primed;
  assign w_want     = (|req | r_toggle | (osd_status & options[0])) & ~cpu_reset;
  assign w_to_done  = (r_to_cnt == TO_LAST);
  assign w_halted   = (r_state == S_PAUSED) || (r_state == S_RESUME);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_vblank_q <= 1'b0;
      r_btn_q    <= 1'b0;
      r_primed   <= 1'b0;
    end else begin
      r_vblank_q <= vblank;
      r_btn_q    <= user_button;
      r_primed   <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_toggle <= 1'b0;
    end else if (cpu_reset) begin
      r_toggle <= 1'b0;
    end else if (w_btn_rise) begin
      r_toggle <= ~r_toggle;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_RUN;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_next;
      r_to_cnt <= w_to_cnt_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_to_cnt_next = r_to_cnt;
    pause_cpu     = 1'b0;
    ack           = '0;
    case (r_state)
      S_RUN: begin
        w_to_cnt_next = '0;
        if (w_want) w_next = S_ARM;
      end
      S_ARM: begin
        if (!w_want) begin
          w_next = S_RUN;
        end else if (w_vb_rise || w_to_done) begin
          w_next = S_PAUSED;
        end else begin
          w_to_cnt_next = r_to_cnt + TW'(1);
        end
      end
      S_PAUSED: begin
        pause_cpu = 1'b1;
        ack       = req;
        if (!w_want) begin
          w_next        = S_RESUME;
          w_to_cnt_next = '0;
        end
      end
      S_RESUME: begin
        pause_cpu = 1'b1;
        if (w_want) begin
          w_next = S_PAUSED;
        end else if (w_vb_rise || w_to_done) begin
          w_next = S_RUN;
        end else begin
          w_to_cnt_next = r_to_cnt + TW'(1);
        end
      end
      default: w_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dim_cnt <= '0;
    end else if (w_halted && options[1]) begin
      if (r_dim_cnt != DIM_MAX) r_dim_cnt <= r_dim_cnt + DW'(1);
    end else begin
      r_dim_cnt <= '0;
    end
  end

  assign dim_video = (r_dim_cnt == DIM_MAX);

endmodule

// File: tb/tb_pause_sequencer.sv
// Bench for pause_sequencer: two instances (long and short vblank timeout)
// driven identically and compared every cycle with a behavioural model.
module tb_pause_sequencer;

  localparam int DIM  = 100;
  localparam int TO_A = 1000;
  localparam int TO_B = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_reset;
  logic [3:0] req;
  logic       btn;
  logic       osd;
  logic [1:0] opt;
  logic       vb;
  logic [3:0] ack_a, ack_b;
  logic       pause_a, pause_b, dim_a, dim_b;

  int n_checks = 0;
  int n_err    = 0;

  // Model: "halted" is whether the CPU is held; "pending" means the wanted
  // halt state differs from the current one and a frame edge is awaited.
  int m_halted[2];
  int m_pending[2];
  int m_wait[2];
  int m_dim[2];
  int m_toggle, m_vb_prev, m_btn_prev, m_primed;

  always #5 clk = ~clk;

  pause_sequencer #(.NREQ(4), .DIM_CYCLES(DIM), .VB_TIMEOUT(TO_A)) u_dut_a (
    .clk_sys(clk), .reset_n(rst_n), .cpu_reset(cpu_reset), .req(req), .ack(ack_a),
    .user_button(btn), .osd_status(osd), .options(opt), .vblank(vb),
    .pause_cpu(pause_a), .dim_video(dim_a));

  pause_sequencer #(.NREQ(4), .DIM_CYCLES(DIM), .VB_TIMEOUT(TO_B)) u_dut_b (
    .clk_sys(clk), .reset_n(rst_n), .cpu_reset(cpu_reset), .req(req), .ack(ack_b),
    .user_button(btn), .osd_status(osd), .options(opt), .vblank(vb),
    .pause_cpu(pause_b), .dim_video(dim_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int limit(input int k);
    return (k == 0) ? TO_A : TO_B;
  endfunction

  function automatic logic [3:0] exp_ack(input int k);
    return (m_halted[k] != 0 && m_pending[k] == 0) ? req : 4'b0000;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_halted[k] = 0; m_pending[k] = 0; m_wait[k] = 0; m_dim[k] = 0;
    end
    m_toggle = 0; m_vb_prev = 0; m_btn_prev = 0; m_primed = 0;
  endtask

  task automatic model_tick();
    bit vbr, btr, want;
    vbr  = (vb == 1'b1) && (m_vb_prev == 0) && (m_primed == 1);
    btr  = (btn == 1'b1) && (m_btn_prev == 0) && (m_primed == 1);
    want = ((req != 4'b0) || (m_toggle == 1) || (osd && opt[0])) && !cpu_reset;
    for (int k = 0; k < 2; k++) begin
      if (m_halted[k] != 0 && opt[1]) m_dim[k] = (m_dim[k] < DIM) ? m_dim[k] + 1 : DIM;
      else m_dim[k] = 0;
      if (int'(want) == m_halted[k]) begin
        m_pending[k] = 0; m_wait[k] = 0;
      end else if (m_pending[k] == 0) begin
        m_pending[k] = 1; m_wait[k] = 0;
      end else if (vbr || m_wait[k] == limit(k) - 1) begin
        m_halted[k] = int'(want); m_pending[k] = 0;
      end else begin
        m_wait[k]++;
      end
    end
    if (cpu_reset) m_toggle = 0;
    else if (btr) m_toggle = 1 - m_toggle;
    m_vb_prev  = int'(vb);
    m_btn_prev = int'(btn);
    m_primed   = 1;
  endtask

  task automatic sample();
    #1;
    check("a_pause", 32'(pause_a), 32'(m_halted[0]));
    check("a_ack",   32'(ack_a),   32'(exp_ack(0)));
    check("a_dim",   32'(dim_a),   32'(m_dim[0] == DIM));
    check("b_pause", 32'(pause_b), 32'(m_halted[1]));
    check("b_ack",   32'(ack_b),   32'(exp_ack(1)));
    check("b_dim",   32'(dim_b),   32'(m_dim[1] == DIM));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_tick();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    sample();
    check("rst_pause", 32'(pause_a), 32'd0);
    check("rst_ack",   32'(ack_a),   32'd0);
    check("rst_dim",   32'(dim_a),   32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int fr_len, fr_pos, b;
    rst_n = 1'b0; cpu_reset = 1'b0; req = '0; btn = 1'b0; osd = 1'b0; opt = 2'b00; vb = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Frame-aligned request; instance B pauses by timeout 20 cycles after ARM.
    for (int c = 0; c < 140; c++) begin
      req = (c >= 10 && c < 80) ? 4'b0100 : 4'b0000;
      vb  = (c >= 50 && c < 53) || (c >= 110 && c < 113);
      sample();
      if (c <= 50) check("frm_hold", 32'(pause_a), 32'd0);
      if (c == 51) begin
        check("frm_pause", 32'(pause_a), 32'd1);
        check("frm_ack",   32'(ack_a),   32'h4);
      end
      if (c == 80)  check("frm_ackdrop", 32'(ack_a), 32'd0);
      if (c == 110) check("frm_still",   32'(pause_a), 32'd1);
      if (c == 111) check("frm_release", 32'(pause_a), 32'd0);
      if (c == 30)  check("to_pre",  32'(pause_b), 32'd0);
      if (c == 31)  check("to_fire", 32'(pause_b), 32'd1);
      tick();
    end

    // Dim timer, option clear, then asynchronous reset while dimmed.
    do_reset();
    for (int c = 0; c < 230; c++) begin
      req   = 4'b0001;
      vb    = (c >= 5 && c < 8);
      opt   = (c >= 110 && c < 112) ? 2'b00 : 2'b10;
      rst_n = (c != 215);
      if (!rst_n) model_reset();
      sample();
      if (c == 6)   check("dim_paused", 32'(pause_a), 32'd1);
      if (c == 105) check("dim_pre",  32'(dim_a), 32'd0);
      if (c == 106) check("dim_on",   32'(dim_a), 32'd1);
      if (c == 110) check("dim_hold", 32'(dim_a), 32'd1);
      if (c == 111) check("dim_clr",  32'(dim_a), 32'd0);
      if (c == 212) check("dim_again", 32'(dim_a), 32'd1);
      if (c == 215) begin
        check("mid_rst_pause", 32'(pause_a), 32'd0);
        check("mid_rst_ack",   32'(ack_a),   32'd0);
        check("mid_rst_dim",   32'(dim_a),   32'd0);
      end
      tick();
    end

    // Abort in ARM, simultaneous drop+vblank, re-pause in RESUME, user toggle, cpu_reset.
    opt = 2'b00;
    do_reset();
    for (int c = 0; c < 371; c++) begin
      req = ((c < 4) || (c >= 20 && c < 30) || (c >= 40 && c < 60) || (c >= 65 && c < 80))
            ? 4'b0001 : 4'b0000;
      vb  = (c >= 10 && c < 13) || (c >= 30 && c < 33) || (c >= 50 && c < 53) ||
            (c >= 70 && c < 73) || (c >= 85 && c < 88) || (c >= 100 && (c % 40) < 3);
      btn = (c >= 100 && c < 103) || (c >= 220 && c < 223) || (c >= 260 && c < 263);
      cpu_reset = (c == 300);
      sample();
      if (c < 40) check("abort_nopause", 32'(pause_a), 32'd0);
      if (c >= 51 && c <= 85) check("repause_hold", 32'(pause_a), 32'd1);
      if (c == 65) check("resume_ack", 32'(ack_a), 32'd0);
      if (c == 66) check("repause_ack", 32'(ack_a), 32'd1);
      if (c == 86)  check("repause_rel", 32'(pause_a), 32'd0);
      if (c == 120) check("tog_pre",  32'(pause_a), 32'd0);
      if (c == 121) check("tog_on",   32'(pause_a), 32'd1);
      if (c == 240) check("tog_hold", 32'(pause_a), 32'd1);
      if (c == 241) check("tog_off",  32'(pause_a), 32'd0);
      if (c == 281) check("tog2_on",  32'(pause_a), 32'd1);
      if (c == 320) check("cpurst_hold", 32'(pause_a), 32'd1);
      if (c == 321) check("cpurst_rel",  32'(pause_a), 32'd0);
      if (c == 362) check("cpurst_togclr", 32'(pause_a), 32'd0);
      tick();
    end

    // Randomized traffic against the model.
    cpu_reset = 1'b0; btn = 1'b0; req = '0;
    do_reset();
    fr_len = 40; fr_pos = 0;
    for (int c = 0; c < 4000; c++) begin
      vb = (fr_pos < 3);
      fr_pos++;
      if (fr_pos >= fr_len) begin
        fr_pos = 0;
        fr_len = ($urandom % 8 == 0) ? 90 : int'($urandom_range(60, 25));
      end
      if ($urandom % 40 == 0) begin
        b = int'($urandom_range(3, 0));
        req[b] = ~req[b];
      end
      btn       = ($urandom % 100) < 2;
      cpu_reset = ($urandom % 250) == 0;
      if ($urandom % 200 == 0) osd = ~osd;
      if ($urandom % 300 == 0) opt = 2'($urandom_range(3, 0));
      rst_n = !(($urandom % 1500) == 0);
      if (!rst_n) model_reset();
      sample();
      tick();
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pause_sequencer.md
Name: pause_sequencer

Overview:
- Frame-aligned pause controller for arcade cores.
- Merges pause sources into one pause decision: NREQ requester req/ack pairs (hiscore, save-state, etc.), user pause button toggle, OSD-open with option.
- Enters and leaves pause only on a vblank rising edge, so the CPU halts between frames.
- Drives pause_cpu and dim_video to the core CPU and the RGB dimming path.

Parameters:
- NREQ, 4, number of request/acknowledge requester pairs (1..8).
- DIM_CYCLES, 120000000, clk_sys cycles paused before dim_video asserts (10 s at 12 MHz).
- VB_TIMEOUT, 1000000, clk_sys cycles to wait for a vblank edge before forcing the transition anyway.

Ports:
- clk_sys  in  1  core system clock.
- reset_n  in  1  asynchronous active-low reset.
- cpu_reset  in  1  core CPU reset (active-high, synchronous sample); clears user toggle, blocks pause.
- req  in  NREQ  per-requester pause request; level, held until ack seen and work done.
- ack  out  NREQ  per-requester grant: CPU is halted at a frame boundary.
- user_button  in  1  user pause button, active-high; rising edge toggles user pause.
- osd_status  in  1  OSD open.
- options  in  2  [0] pause when OSD open; [1] enable dim timer.
- vblank  in  1  vertical blank from video timing.
- pause_cpu  out  1  halt CPU, active-high.
- dim_video  out  1  dim RGB request, active-high.

Behaviour:
- Reset (reset_n=0, async):
  - State RUN; pause_cpu=0, ack=0, dim_video=0.
  - User toggle, dim counter and timeout counter cleared.
  - Edge-detect registers cleared to 0.
- Edge detection:
  - vb_rise = vblank & !vblank_q.
  - btn_rise = user_button & !btn_q.
  - All registered; first cycle after reset never produces an edge from a held-high input.
- User toggle:
  - Flips on btn_rise.
  - Cleared whenever cpu_reset=1; cpu_reset has priority over a same-cycle btn_rise.
- want = (|req | toggle | (osd_status & options[0])) & !cpu_reset.
- States (registered; outputs are decoded from the state register):
  - RUN: pause_cpu=0. If want, go to ARM; clear timeout counter.
  - ARM: pause_cpu=0.
    - If !want, return to RUN.
    - Else if vb_rise or timeout counter reaches VB_TIMEOUT-1, go to PAUSED.
    - Else increment timeout counter.
  - PAUSED: pause_cpu=1.
    - ack[i]=req[i] (combinational AND with state). ack drops in the same cycle req drops.
    - If !want, go to RESUME; clear timeout counter.
  - RESUME: pause_cpu=1, ack=0.
    - If want reasserts, return to PAUSED; no vblank wait, CPU is still halted.
    - Else if vb_rise or timeout counter reaches VB_TIMEOUT-1, go to RUN.
- Latencies:
  - pause_cpu rises in the cycle after the vb_rise cycle seen in ARM.
  - It falls in the cycle after the vb_rise seen in RESUME.
- cpu_reset=1 in any state:
  - want=0, so PAUSED goes to RESUME and releases at the next frame edge.
  - ARM goes to RUN immediately.
- Dim counter:
  - Counts in PAUSED or RESUME while options[1]=1; saturates at DIM_CYCLES.
  - Cleared otherwise.
  - dim_video = (count == DIM_CYCLES).
- Simultaneous events:
  - want dropping in the same cycle as vb_rise in ARM: go to RUN (want has priority).
  - New req arriving in PAUSED: acked in the same cycle, no frame wait.
- Counter widths: $clog2(max+1) bits. No wrap-around; both counters saturate.

Test Plan:
- Reset mid-operation: reach PAUSED, pulse reset_n low for 1 cycle -> pause_cpu=0, ack=0, dim_video=0 immediately (async), state RUN.
- Frame-aligned request:
  - Stimulus: req[2]=1 at cycle 10, vblank rises at cycle 50.
  - Required: pause_cpu=0 through cycle 50, pause_cpu=1 and ack=4'b0100 from cycle 51.
  - Then drop req[2] -> ack=0 same cycle; pause_cpu stays 1 until the next vblank rise +1.
- User toggle:
  - Two button presses 3 frames apart -> pause_cpu high for the frames between the vblank edges.
  - cpu_reset pulse while paused -> toggle cleared, release at next vblank.
- Abort and re-pause:
  - req drops in ARM before vblank -> state RUN, pause_cpu never asserted.
  - req reasserts in RESUME -> back to PAUSED, pause_cpu stays 1 continuously.
- Timeout: vblank held low, DIM_CYCLES=100, VB_TIMEOUT=20 -> pause_cpu=1 exactly 20 cycles after entering ARM.
- Dim: with options=2'b10, paused, DIM_CYCLES=100 -> dim_video=1 after 100 cycles in PAUSED; options[1]=0 -> dim_video=0 next cycle, counter cleared.
